// File: rtl/ooo_types_pkg.sv
// Shared out-of-order core types: ROB index/age types, age unwrap helper and load funct3 codes.
package ooo_types_pkg;

  localparam int unsigned MaxRobW = 16;

  typedef logic [MaxRobW-1:0] rob_idx_t;
  typedef logic [MaxRobW:0]   rob_age_t;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  // Distance of idx from the ROB head, wrapping modulo the ROB depth.
  function automatic rob_age_t unwrap(input rob_age_t idx, input rob_age_t head,
                                      input rob_age_t depth);
    rob_age_t diff;
    diff = idx - head;
    if (idx < head) diff = diff + depth;
    return diff;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      F3Lh, F3Lhu: return lo[0];
      F3Lw:        return |lo;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane helper: byte-lane read mask from funct3/addr[1:0], and extraction/extension of data.
module load_align
  import ooo_types_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  rmask,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    rmask   = 4'b1111;
    data    = shifted;
    case (funct3)
      F3Lb: begin
        rmask = 4'b0001 << addr_lo;
        data  = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3Lbu: begin
        rmask = 4'b0001 << addr_lo;
        data  = {24'b0, shifted[7:0]};
      end
      // Lanes shifted past bit 3 drop out of the 4-bit mask.
      F3Lh: begin
        rmask = 4'b0011 << addr_lo;
        data  = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3Lhu: begin
        rmask = 4'b0011 << addr_lo;
        data  = {16'b0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_queue.sv
// Load queue: holds address-resolved loads, issues the oldest unblocked one to dmem, drives the CDB.
// Define LQ_MISALIGN_EXC_EN to turn misaligned loads into exception broadcasts instead of issues.
module load_queue
  import ooo_types_pkg::*;
#(
  parameter int unsigned NUM_LQ_ENTRIES  = 8,
  parameter int unsigned NUM_ROB_ENTRIES = 64,
  parameter int unsigned PRW             = 6,
  localparam int unsigned ROBW           = $clog2(NUM_ROB_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [ROBW-1:0] rob_head_idx,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  input  logic [ROBW-1:0] alloc_rob_idx,
  input  logic [PRW-1:0]  alloc_pd,
  input  logic [31:0]     alloc_addr,
  input  logic [2:0]      alloc_funct3,
  output logic [ROBW-1:0] cand_rob_idx,
  input  logic            cand_has_older_store_unknown,
  output logic            dmem_req,
  output logic [31:0]     dmem_addr,
  output logic [3:0]      dmem_rmask,
  input  logic            dmem_resp,
  input  logic [31:0]     dmem_rdata,
  output logic            cdb_valid,
  output logic [ROBW-1:0] cdb_rob_idx,
  output logic [PRW-1:0]  cdb_pd,
  output logic [31:0]     cdb_data,
  output logic            cdb_exc
);

  localparam int unsigned LQW  = $clog2(NUM_LQ_ENTRIES);
  localparam int unsigned AgeW = ROBW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e              state_q;
  logic [NUM_LQ_ENTRIES-1:0] valid_q;
  logic [ROBW-1:0]     rob_q  [NUM_LQ_ENTRIES];
  logic [PRW-1:0]      pd_q   [NUM_LQ_ENTRIES];
  logic [31:0]         addr_q [NUM_LQ_ENTRIES];
  logic [2:0]          f3_q   [NUM_LQ_ENTRIES];
  logic [LQW:0]        occ_q;

  logic [ROBW-1:0]     inf_rob_q;
  logic [PRW-1:0]      inf_pd_q;
  logic [1:0]          inf_lo_q;
  logic [2:0]          inf_f3_q;

  logic                cand_valid;
  logic [LQW-1:0]      cand_slot;
  logic [AgeW-1:0]     best_age;
  logic [AgeW-1:0]     age_i;
  logic                free_found;
  logic [LQW-1:0]      free_slot;
  logic [31:0]         cand_addr;
  logic [2:0]          cand_f3;
  logic                cand_mis;
  logic                issue;
  logic                exc_fire;
  logic                alloc_fire;
  logic [2:0]          align_f3;
  logic [1:0]          align_lo;
  logic [3:0]          align_rmask;
  logic [31:0]         align_data;

  // Oldest valid entry relative to the ROB head; strict compare keeps the lower slot on ties.
  always_comb begin
    cand_valid = 1'b0;
    cand_slot  = '0;
    best_age   = '1;
    age_i      = '0;
    for (int i = 0; i < NUM_LQ_ENTRIES; i++) begin
      age_i = AgeW'(unwrap(rob_age_t'(rob_q[i]), rob_age_t'(rob_head_idx),
                           rob_age_t'(NUM_ROB_ENTRIES)));
      if (valid_q[i] && (!cand_valid || age_i < best_age)) begin
        cand_valid = 1'b1;
        cand_slot  = LQW'(i);
        best_age   = age_i;
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = NUM_LQ_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_slot  = LQW'(i);
      end
    end
  end

  assign cand_addr    = addr_q[cand_slot];
  assign cand_f3      = f3_q[cand_slot];
  assign cand_rob_idx = cand_valid ? rob_q[cand_slot] : '0;

`ifdef LQ_MISALIGN_EXC_EN
  assign cand_mis = is_misaligned(cand_f3, cand_addr[1:0]);
`else
  assign cand_mis = 1'b0;
`endif

  assign alloc_ready = (occ_q < (LQW + 1)'(NUM_LQ_ENTRIES));
  assign alloc_fire  = alloc_valid && alloc_ready && free_found && !flush;
  assign issue       = (state_q == StIdle) && cand_valid && !flush && !cand_mis &&
                       !cand_has_older_store_unknown;
  assign exc_fire    = (state_q == StIdle) && cand_valid && !flush && cand_mis;

  // Mask is needed at issue (IDLE); extraction at response (WAIT) uses the in-flight entry.
  assign align_f3 = (state_q == StIdle) ? cand_f3 : inf_f3_q;
  assign align_lo = (state_q == StIdle) ? cand_addr[1:0] : inf_lo_q;

  load_align u_align (
    .funct3  (align_f3),
    .addr_lo (align_lo),
    .rdata   (dmem_rdata),
    .rmask   (align_rmask),
    .data    (align_data)
  );

  assign dmem_req   = issue;
  assign dmem_addr  = issue ? {cand_addr[31:2], 2'b00} : 32'h0;
  assign dmem_rmask = issue ? align_rmask : 4'b0000;

`ifdef LQ_MISALIGN_EXC_EN
  logic cdb_exc_q;
  always_ff @(posedge clk) begin
    if (rst) cdb_exc_q <= 1'b0;
    else     cdb_exc_q <= exc_fire;
  end
  assign cdb_exc = cdb_exc_q;
`else
  assign cdb_exc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      occ_q       <= '0;
      inf_rob_q   <= '0;
      inf_pd_q    <= '0;
      inf_lo_q    <= '0;
      inf_f3_q    <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_pd      <= '0;
      cdb_data    <= '0;
    end else begin
      cdb_valid <= 1'b0;

      if (flush) begin
        valid_q <= '0;
        occ_q   <= '0;
      end else begin
        if (alloc_fire) begin
          valid_q[free_slot] <= 1'b1;
          rob_q[free_slot]   <= alloc_rob_idx;
          pd_q[free_slot]    <= alloc_pd;
          addr_q[free_slot]  <= alloc_addr;
          f3_q[free_slot]    <= alloc_funct3;
        end
        if (issue || exc_fire) valid_q[cand_slot] <= 1'b0;
        occ_q <= occ_q + (LQW + 1)'(alloc_fire) - (LQW + 1)'(issue || exc_fire);
      end

      case (state_q)
        StIdle: begin
          if (issue) begin
            inf_rob_q <= rob_q[cand_slot];
            inf_pd_q  <= pd_q[cand_slot];
            inf_lo_q  <= cand_addr[1:0];
            inf_f3_q  <= cand_f3;
            state_q   <= StWait;
          end else if (exc_fire) begin
            cdb_valid   <= 1'b1;
            cdb_rob_idx <= rob_q[cand_slot];
            cdb_pd      <= pd_q[cand_slot];
            cdb_data    <= 32'h0;
          end
        end
        StWait: begin
          if (dmem_resp) begin
            if (!flush) begin
              cdb_valid   <= 1'b1;
              cdb_rob_idx <= inf_rob_q;
              cdb_pd      <= inf_pd_q;
              cdb_data    <= align_data;
            end
            state_q <= StIdle;
          end else if (flush) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (dmem_resp) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_queue.sv
// Self-checking bench for load_queue: scoreboard of expected CDB results plus directed checks.
module tb_load_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  rob_head_idx;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [5:0]  alloc_rob_idx;
  logic [5:0]  alloc_pd;
  logic [31:0] alloc_addr;
  logic [2:0]  alloc_funct3;
  logic [5:0]  cand_rob_idx;
  logic        cand_has_older_store_unknown;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        cdb_valid;
  logic [5:0]  cdb_rob_idx;
  logic [5:0]  cdb_pd;
  logic [31:0] cdb_data;
  logic        cdb_exc;

  typedef struct {
    logic [5:0]  rob;
    logic [5:0]  pd;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat;

  always #5 clk = ~clk;

  load_queue dut (
    .clk                          (clk),
    .rst                          (rst),
    .flush                        (flush),
    .rob_head_idx                 (rob_head_idx),
    .alloc_valid                  (alloc_valid),
    .alloc_ready                  (alloc_ready),
    .alloc_rob_idx                (alloc_rob_idx),
    .alloc_pd                     (alloc_pd),
    .alloc_addr                   (alloc_addr),
    .alloc_funct3                 (alloc_funct3),
    .cand_rob_idx                 (cand_rob_idx),
    .cand_has_older_store_unknown (cand_has_older_store_unknown),
    .dmem_req                     (dmem_req),
    .dmem_addr                    (dmem_addr),
    .dmem_rmask                   (dmem_rmask),
    .dmem_resp                    (dmem_resp),
    .dmem_rdata                   (dmem_rdata),
    .cdb_valid                    (cdb_valid),
    .cdb_rob_idx                  (cdb_rob_idx),
    .cdb_pd                       (cdb_pd),
    .cdb_data                     (cdb_data),
    .cdb_exc                      (cdb_exc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cdb_valid) begin
      if (exp_q.size() == 0) begin
        check("cdb_unexpected_rob", 32'(cdb_rob_idx), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("cdb_rob", 32'(cdb_rob_idx), 32'(mon_e.rob));
        check("cdb_pd", 32'(cdb_pd), 32'(mon_e.pd));
        check("cdb_data", cdb_data, mon_e.data);
        check("cdb_exc", 32'(cdb_exc), 32'(mon_e.exc));
      end
    end
  end

  task automatic push_exp(input logic [5:0] rob, input logic [5:0] pd, input logic [31:0] data,
                          input logic exc);
    exp_t e;
    e.rob = rob; e.pd = pd; e.data = data; e.exc = exc;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at the following posedge+1 with the load accepted.
  task automatic do_alloc(input logic [5:0] rob, input logic [5:0] pd, input logic [31:0] addr,
                          input logic [2:0] f3);
    alloc_valid = 1'b1; alloc_rob_idx = rob; alloc_pd = pd; alloc_addr = addr;
    alloc_funct3 = f3;
    @(negedge clk);
    check("alloc_ready", 32'(alloc_ready), 32'd1);
    @(posedge clk); #1;
    alloc_valid = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] addr, input logic [3:0] mask, output int cycles);
    logic found = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dmem_req) found = 1'b1;
      else cycles++;
    end
    check("req_seen", 32'(found), 32'd1);
    if (found) begin
      check("dmem_addr", dmem_addr, addr);
      check("dmem_rmask", 32'(dmem_rmask), 32'(mask));
    end
  endtask

  task automatic respond(input logic [31:0] data);
    @(posedge clk); #1;
    check("req_one_cycle", 32'(dmem_req), 32'd0);
    dmem_resp = 1'b1; dmem_rdata = data;
    @(posedge clk); #1;
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic one_load(input logic [5:0] rob, input logic [5:0] pd, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic [3:0] exp_mask);
    int c;
    push_exp(rob, pd, exp_data, 1'b0);
    do_alloc(rob, pd, addr, f3);
    wait_req({addr[31:2], 2'b00}, exp_mask, c);
    respond(rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; rob_head_idx = '0; alloc_valid = 1'b0; alloc_rob_idx = '0;
    alloc_pd = '0; alloc_addr = '0; alloc_funct3 = '0; cand_has_older_store_unknown = 1'b0;
    dmem_resp = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_exc", 32'(cdb_exc), 32'd0);
    check("rst_cdb_data", cdb_data, 32'd0);
    check("rst_cand", 32'(cand_rob_idx), 32'd0);
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic LW, one-cycle allocation-to-issue latency.
    push_exp(6'd5, 6'd7, 32'hDEAD_BEEF, 1'b0);
    do_alloc(6'd5, 6'd7, 32'h0000_1004, 3'b010);
    wait_req(32'h0000_1004, 4'b1111, lat);
    check("issue_latency", 32'(lat), 32'd0);
    respond(32'hDEAD_BEEF);

    // Byte/half extraction and extension.
    one_load(6'd6, 6'd8, 32'h1003, 3'b000, 32'h8000_0000, 32'hFFFF_FF80, 4'b1000);
    one_load(6'd7, 6'd9, 32'h1003, 3'b100, 32'h8000_0000, 32'h0000_0080, 4'b1000);
    one_load(6'd8, 6'd10, 32'h1002, 3'b001, 32'h8001_0000, 32'hFFFF_8001, 4'b1100);
    one_load(6'd9, 6'd11, 32'h1002, 3'b101, 32'h8001_0000, 32'h0000_8001, 4'b1100);
    one_load(6'd10, 6'd12, 32'h1001, 3'b000, 32'h0000_7F00, 32'h0000_007F, 4'b0010);

    // Age ordering across the ROB wrap, and store-guard blocking.
    rob_head_idx = 6'd60;
    cand_has_older_store_unknown = 1'b1;
    push_exp(6'd62, 6'd3, 32'h6262_6262, 1'b0);
    push_exp(6'd2, 6'd2, 32'h0202_0202, 1'b0);
    do_alloc(6'd2, 6'd2, 32'h2000, 3'b010);
    do_alloc(6'd62, 6'd3, 32'h2040, 3'b010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("guard_blocks", 32'(dmem_req), 32'd0);
      check("cand_oldest", 32'(cand_rob_idx), 32'd62);
    end
    @(posedge clk); #1;
    cand_has_older_store_unknown = 1'b0;
    wait_req(32'h2040, 4'b1111, lat);
    respond(32'h6262_6262);
    wait_req(32'h2000, 4'b1111, lat);
    respond(32'h0202_0202);

    // Fill to capacity, then release one issue.
    rob_head_idx = 6'd0;
    cand_has_older_store_unknown = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_exp(6'(10 + i), 6'(20 + i), 32'hA500_0000 | 32'(i), 1'b0);
      do_alloc(6'(10 + i), 6'(20 + i), 32'h3000 + 32'(4 * i), 3'b010);
    end
    check("full_not_ready", 32'(alloc_ready), 32'd0);
    cand_has_older_store_unknown = 1'b0;
    wait_req(32'h3000, 4'b1111, lat);
    check("ready_issue_cycle", 32'(alloc_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_issue", 32'(alloc_ready), 32'd1);
    respond(32'hA500_0000);
    for (int i = 1; i < 8; i++) begin
      wait_req(32'h3000 + 32'(4 * i), 4'b1111, lat);
      respond(32'hA500_0000 | 32'(i));
    end

    // Flush while waiting: response discarded, no issue during drain.
    cand_has_older_store_unknown = 1'b1;
    do_alloc(6'd20, 6'd30, 32'h4000, 3'b010);
    do_alloc(6'd21, 6'd31, 32'h4004, 3'b010);
    cand_has_older_store_unknown = 1'b0;
    wait_req(32'h4000, 4'b1111, lat);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_empty_cand", 32'(cand_rob_idx), 32'd0);
    push_exp(6'd22, 6'd32, 32'h2222_2222, 1'b0);
    do_alloc(6'd22, 6'd32, 32'h4100, 3'b010);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("drain_no_issue", 32'(dmem_req), 32'd0);
    end
    @(posedge clk); #1;
    dmem_resp = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    wait_req(32'h4100, 4'b1111, lat);
    respond(32'h2222_2222);

    // Flush in IDLE suppresses a same-cycle issue.
    cand_has_older_store_unknown = 1'b1;
    do_alloc(6'd30, 6'd33, 32'h5000, 3'b010);
    cand_has_older_store_unknown = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_no_issue", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle_empty", 32'(cand_rob_idx), 32'd0);
    @(negedge clk);
    check("flush_idle_stays_idle", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;

`ifdef LQ_MISALIGN_EXC_EN
    // Misaligned LW: never issued, exception broadcast even while guard blocks.
    cand_has_older_store_unknown = 1'b1;
    push_exp(6'd40, 6'd9, 32'h0, 1'b1);
    do_alloc(6'd40, 6'd9, 32'h1002, 3'b010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("misalign_no_req", 32'(dmem_req), 32'd0);
    end
    check("misalign_cdb_seen", 32'(exp_q.size()), 32'd0);
    cand_has_older_store_unknown = 1'b0;
    @(posedge clk); #1;
`else
    // Misaligned LH issues; the mask keeps only in-word lanes.
    one_load(6'd41, 6'd14, 32'h1003, 3'b001, 32'h8000_0000, 32'h0000_0080, 4'b1000);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
